machine_timer: RTL
==================

# machine_timer

Memory-mapped RISC-V machine timer holding the 64-bit `mtime` counter and the `mtimecmp` comparator. It drives the level-sensitive machine timer interrupt pending line into the CSR unit's `i_Int_tip` input, which becomes `mip.MTIP`. It sits on the data bus as a small slave with a one-cycle request/acknowledge handshake and occupies a 16-byte window.

## Interface

Clock is `i_clk`. Reset is `i_rst`, synchronous and active-high.

Parameters:
- `PRESCALE`, default 1: number of clock cycles per `mtime` increment. Legal range is 1..65535. It is used only when `TIMER_PRESCALE_EN` is defined.

Ports:
- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous active-high reset
- `i_req`  in  1  bus request, valid for one cycle per access
- `i_we`  in  1  1 = write, 0 = read; qualified by `i_req`
- `i_addr`  in  4  byte offset within the window
- `i_wdata`  in  32  write data; full-word writes only
- `o_rdata`  out  32  registered read data, valid while `o_ack` = 1
- `o_ack`  out  1  access acknowledge, one cycle after `i_req`
- `o_tip`  out  1  timer interrupt pending; connects to the CSR `i_Int_tip`

## Operation

Register map:
- 0x0: `mtime[31:0]`
- 0x4: `mtime[63:32]`
- 0x8: `mtimecmp[31:0]`
- 0xC: `mtimecmp[63:32]`

Reset values:
- `mtime` = 0
- `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, so no interrupt fires out of reset
- `mtime_hi` snapshot = 0
- prescale counter = 0
- `o_tip`, `o_ack`, `o_rdata` = 0

Counting:
- `mtime` increments by 1 on each tick. A tick is every cycle, or one cycle in `PRESCALE` when the macro is defined.
- The counter is 64-bit unsigned and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 without any flag.

Writes:
- A write to either `mtime` half loads that half with `i_wdata`. The other half holds its value.
- The increment is suppressed in the write cycle, and the prescale counter is cleared.
- `mtimecmp` writes load the addressed half only and never affect counting.

Reads and the tear-free snapshot:
- A read of 0x0 returns `mtime[31:0]` and, in the same edge, latches `mtime[63:32]` into the snapshot register.
- A read of 0x4 returns the snapshot, not the live high word. Software must read 0x0 before 0x4.
- Reads of 0x8 and 0xC return the live `mtimecmp` halves.

Illegal addresses:
- An access with `i_addr[1:0]` ≠ 0 is still acknowledged.
- For such an access, read data is 0 and writes are dropped.

Compare:
- `o_tip` is set when `mtime` >= `mtimecmp`, using an unsigned 64-bit compare.
- `o_tip` stays asserted until software raises `mtimecmp` or rewrites `mtime` below it. There is no separate clear.

## Timing

Handshake:
- `o_ack` = `i_req` delayed by one cycle.
- `o_rdata` updates on the same edge as `o_ack` and is 0 when `o_ack` = 0 or for writes.
- Back-to-back requests on consecutive cycles are all accepted. There is no stall.

Write effect:
- A write sampled at edge k makes the register value visible from edge k.
- A read of the same register issued in cycle k returns the new value.

Interrupt latency:
- `o_tip` is registered: its value after edge k+1 is the compare of the register values held between edges k and k+1.
- Crossing the compare value therefore raises `o_tip` exactly one cycle after `mtime` reaches `mtimecmp`.
- A write that lowers or raises the compare result changes `o_tip` one edge after the write edge.

Simultaneous events:
- A write to `mtime` in the cycle a tick is due: the write wins, the tick is lost, and the prescaler restarts.
- A read of 0x0 together with a tick: the read returns the pre-increment low word, and the snapshot captures the pre-increment high word. Both come from the same edge, so the pair is consistent.

Reset mid-operation:
- A reset asserted in any cycle restores all reset values at the next edge.
- A request pending in that cycle is dropped, and `o_ack` = 0 after the reset edge.

## Configuration

`TIMER_PRESCALE_EN` defined:
- A 16-bit prescale counter counts 0..`PRESCALE`-1.
- A tick occurs when the counter equals `PRESCALE`-1, and the counter then returns to 0.
- `PRESCALE` = 1 behaves like a tick every cycle.

`TIMER_PRESCALE_EN` undefined:
- No prescale counter is built, and `PRESCALE` is ignored.
- `mtime` ticks every cycle.

## Test plan

- Reset, then idle 10 cycles → `mtime` = 10, `o_tip` = 0, and reading 0x8/0xC returns 0xFFFF_FFFF twice.
- Write 0x0 = 0xFFFF_FFFE and 0x4 = 0xFFFF_FFFF, idle 3 cycles, read 0x0 then 0x4 → the counter has wrapped; the read pair returns 0x0000_0000/0x0000_0000 or later low values with a consistent high word of 0.
- Write `mtimecmp` = 20 (0xC = 0 first, then 0x8 = 20) with `mtime` near 0 → `o_tip` rises exactly one cycle after `mtime` = 20; writing 0x8 = 1000 drops `o_tip` one edge later.
- Set `mtime` = 0x0000_0000_FFFF_FFFF, read 0x0 on the edge the low word carries, then read 0x4 → the high word matches the captured low word (0xFFFF_FFFF with 0, or 0 with 1), never torn.
- Read 0x2, then write 0x6 with 0x1234 → `o_ack` pulses for both accesses, `o_rdata` = 0, and no register changes.
- With `TIMER_PRESCALE_EN` and `PRESCALE` = 4: 40 idle cycles → `mtime` = 10. A write to `mtime` mid-period restarts the period, so the next increment comes 4 cycles after the write.

Source files
------------

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with a one-cycle bus handshake and a registered MTIP output.
// Optional tick prescaler is built only when TIMER_PRESCALE_EN is defined.
module machine_timer #(
  parameter int PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_tip
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] mtime_hi_snap;
  logic [31:0] rdata_next;
  logic        tick;
  logic        access_ok;
  logic        wr_time_lo;
  logic        wr_time_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        rd_time_lo;

  prescale_legal: assert property (@(posedge i_clk) (PRESCALE >= 1) && (PRESCALE <= 65535));

  // Misaligned offsets are acknowledged but never touch a register.
  assign access_ok = i_req && (i_addr[1:0] == 2'b00);

  always_comb begin
    wr_time_lo = 1'b0;
    wr_time_hi = 1'b0;
    wr_cmp_lo  = 1'b0;
    wr_cmp_hi  = 1'b0;
    rd_time_lo = 1'b0;
    rdata_next = '0;
    if (access_ok) begin
      if (i_we) begin
        case (i_addr[3:2])
          2'd0:    wr_time_lo = 1'b1;
          2'd1:    wr_time_hi = 1'b1;
          2'd2:    wr_cmp_lo  = 1'b1;
          default: wr_cmp_hi  = 1'b1;
        endcase
      end else begin
        case (i_addr[3:2])
          2'd0: begin
            rd_time_lo = 1'b1;
            rdata_next = mtime[31:0];
          end
          2'd1:    rdata_next = mtime_hi_snap;
          2'd2:    rdata_next = mtimecmp[31:0];
          default: rdata_next = mtimecmp[63:32];
        endcase
      end
    end
  end

`ifdef TIMER_PRESCALE_EN
  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0] prescale_cnt;

  assign tick = (prescale_cnt == PRESCALE_LAST);

  // A write to mtime restarts the period so the next increment is a full period away.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prescale_cnt <= '0;
    end else if (wr_time_lo || wr_time_hi || tick) begin
      prescale_cnt <= '0;
    end else begin
      prescale_cnt <= prescale_cnt + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Software writes win over a tick due in the same cycle; the untouched half holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime <= '0;
    end else if (wr_time_lo) begin
      mtime[31:0] <= i_wdata;
    end else if (wr_time_hi) begin
      mtime[63:32] <= i_wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtimecmp <= '1;
    end else if (wr_cmp_lo) begin
      mtimecmp[31:0] <= i_wdata;
    end else if (wr_cmp_hi) begin
      mtimecmp[63:32] <= i_wdata;
    end
  end

  // The high word is captured with the low-word read so a 0x0/0x4 pair never tears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime_hi_snap <= '0;
    end else if (rd_time_lo) begin
      mtime_hi_snap <= mtime[63:32];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ack   <= 1'b0;
      o_rdata <= '0;
      o_tip   <= 1'b0;
    end else begin
      o_ack   <= i_req;
      o_rdata <= rdata_next;
      o_tip   <= (mtime >= mtimecmp);
    end
  end

endmodule
